// File: rtl/rs_dec_pkg.sv
// rtl/rs_dec_pkg.sv - shared widths, FSM state and result record for the RS decode scheduler
package rs_dec_pkg;

    localparam int DATA_W        = 105;  // 21 data symbols
    localparam int SYND_W        = 25;   // 5 syndrome symbols
    localparam int ERR_W         = 3;
    localparam int SYM_W         = 5;
    localparam int TAG_W         = 8;
    localparam int T_MAX_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP,
        FAULT
    } state_e;

    // One buffered completion, as stored in the result FIFO.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              pkt_new;
        logic [ERR_W-1:0]  errors;
        logic [TAG_W-1:0]  seq;
    } result_t;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/rs_result_fifo.sv
// rtl/rs_result_fifo.sv - synchronous show-ahead FIFO holding decoded results
// Ports: clk/rst (sync, active-high), wr_en/wr_data push, rd_en pop,
// rd_data shows the head entry whenever valid is high, count = entries held.
module rs_result_fifo #(
    parameter int WIDTH = 117,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    always_comb begin
        full  = (count_q == DEPTH_C);
        do_rd = rd_en & (count_q != '0);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        do_wr = wr_en & (~full | do_rd);

        wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + 1'b1;
        end else if (!do_wr && do_rd) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign valid   = (count_q != '0);
    assign count   = count_q;

endmodule

// File: rtl/rs_decode_scheduler.sv
// rtl/rs_decode_scheduler.sv - issues codewords to the RS decoder core and buffers tagged results
// Ports: aclk/areset (sync, active-high); enable gates new issues; clear_fault leaves FAULT;
// cw_* codeword input handshake; core_* issue/completion interface to the decoder core;
// res_* show-ahead result handshake; cnt_* saturating statistics; err_* sticky flags; busy.
module rs_decode_scheduler
    import rs_dec_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4,
    parameter int MIN_GAP      = 2,
    parameter int TIMEOUT      = 255,
    parameter int T_MAX        = T_MAX_DEFAULT
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              enable,
    input  logic              clear_fault,
    input  logic              cw_valid,
    output logic              cw_ready,
    input  logic [DATA_W-1:0] cw_data,
    input  logic [SYND_W-1:0] cw_synd,
    output logic              core_vld,
    output logic [DATA_W-1:0] core_dta,
    output logic [SYND_W-1:0] core_synd,
    input  logic              core_pkt_vld,
    input  logic [DATA_W-1:0] core_pkt_dta,
    input  logic              core_pkt_new,
    input  logic [ERR_W-1:0]  core_pkt_errors,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_new,
    output logic [ERR_W-1:0]  res_errors,
    output logic              res_uncorr,
    output logic [TAG_W-1:0]  res_seq,
    output logic [15:0]       cnt_cw,
    output logic [15:0]       cnt_corr_sym,
    output logic [15:0]       cnt_uncorr,
    output logic              err_timeout,
    output logic              err_spurious,
    output logic              busy
);

    localparam int IW = $clog2(MAX_INFLIGHT) + 1;
    localparam logic [IW:0]      SLOT_LIMIT = (IW+1)'(MAX_INFLIGHT);
    localparam logic [7:0]       GAP_LAST   = 8'(MIN_GAP - 1);
    localparam logic [8:0]       WD_LIMIT   = 9'(TIMEOUT);
    localparam logic [ERR_W-1:0] T_MAX_E    = ERR_W'(T_MAX);

    state_e            state_q, state_d;
    logic [7:0]        gap_q, gap_d;
    logic [IW-1:0]     inflight_q, inflight_d;
    logic [7:0]        wd_q, wd_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0] dta_q, dta_d;
    logic [SYND_W-1:0] synd_q, synd_d;
    logic [15:0]       cnt_cw_q, cnt_cw_d;
    logic [15:0]       cnt_corr_q, cnt_corr_d;
    logic [15:0]       cnt_uncorr_q, cnt_uncorr_d;
    logic              err_to_q, err_to_d;
    logic              err_sp_q, err_sp_d;

    logic              accept, issue, comp, spurious, expire, clear_ok;
    logic [8:0]        wd_inc;
    logic [IW-1:0]     fifo_count;
    logic              fifo_valid, fifo_rd;
    result_t           wr_entry, rd_entry;

    assign accept   = cw_valid & cw_ready;
    assign issue    = (state_q == ISSUE);
    assign comp     = core_pkt_vld & (inflight_q != '0);
    assign spurious = core_pkt_vld & (inflight_q == '0);
    assign wd_inc   = {1'b0, wd_q} + 9'd1;
    // A completion in the expiry cycle rescues the core, so it blocks the fault.
    assign expire   = (inflight_q != '0) & ~core_pkt_vld & (wd_inc == WD_LIMIT);
    assign clear_ok = clear_fault & (state_q == FAULT);

    // FSM: state register
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= IDLE;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE:  if (accept) state_d = ISSUE;
            ISSUE: begin
                state_d = GAP;
                gap_d   = '0;
            end
            GAP: begin
                if (gap_q == GAP_LAST) state_d = IDLE;
                else gap_d = gap_q + 8'd1;
            end
            FAULT: if (clear_fault) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (expire) state_d = FAULT;
    end

    // FSM: outputs
    always_comb begin
        core_vld = (state_q == ISSUE);
        cw_ready = (state_q == IDLE) & enable &
                   (({1'b0, inflight_q} + {1'b0, fifo_count}) < SLOT_LIMIT);
        busy     = (state_q != IDLE) | (inflight_q != '0) | (fifo_count != '0);
    end

    // Datapath, credit, watchdog and statistics
    always_comb begin
        dta_d  = accept ? cw_data : dta_q;
        synd_d = accept ? cw_synd : synd_q;

        if (expire) begin
            inflight_d = '0;
        end else begin
            inflight_d = inflight_q + {{(IW-1){1'b0}}, issue} - {{(IW-1){1'b0}}, comp};
        end

        wd_d = wd_q;
        if (clear_ok || expire || core_pkt_vld || (issue && inflight_q == '0)) begin
            wd_d = '0;
        end else if (inflight_q != '0) begin
            wd_d = wd_inc[7:0];
        end

        tag_d        = comp ? tag_q + 8'd1 : tag_q;
        cnt_cw_d     = cnt_cw_q;
        cnt_corr_d   = cnt_corr_q;
        cnt_uncorr_d = cnt_uncorr_q;
        if (comp) begin
            cnt_cw_d = sat_add16(cnt_cw_q, 16'd1);
            if (core_pkt_errors > T_MAX_E) begin
                cnt_uncorr_d = sat_add16(cnt_uncorr_q, 16'd1);
            end else begin
                cnt_corr_d = sat_add16(cnt_corr_q, {13'd0, core_pkt_errors});
            end
        end

        err_to_d = clear_ok ? 1'b0 : err_to_q;
        err_sp_d = clear_ok ? 1'b0 : err_sp_q;
        if (expire)   err_to_d = 1'b1;
        if (spurious) err_sp_d = 1'b1;

        wr_entry.data    = core_pkt_dta;
        wr_entry.pkt_new = core_pkt_new;
        wr_entry.errors  = core_pkt_errors;
        wr_entry.seq     = tag_q;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            inflight_q   <= '0;
            wd_q         <= '0;
            tag_q        <= '0;
            dta_q        <= '0;
            synd_q       <= '0;
            cnt_cw_q     <= '0;
            cnt_corr_q   <= '0;
            cnt_uncorr_q <= '0;
            err_to_q     <= 1'b0;
            err_sp_q     <= 1'b0;
        end else begin
            inflight_q   <= inflight_d;
            wd_q         <= wd_d;
            tag_q        <= tag_d;
            dta_q        <= dta_d;
            synd_q       <= synd_d;
            cnt_cw_q     <= cnt_cw_d;
            cnt_corr_q   <= cnt_corr_d;
            cnt_uncorr_q <= cnt_uncorr_d;
            err_to_q     <= err_to_d;
            err_sp_q     <= err_sp_d;
        end
    end

    assign fifo_rd = fifo_valid & res_ready;

    rs_result_fifo #(
        .WIDTH ($bits(result_t)),
        .DEPTH (MAX_INFLIGHT)
    ) u_fifo (
        .clk     (aclk),
        .rst     (areset),
        .wr_en   (comp),
        .wr_data (wr_entry),
        .rd_en   (fifo_rd),
        .rd_data (rd_entry),
        .valid   (fifo_valid),
        .count   (fifo_count)
    );

    // Result fields read as zero whenever nothing is presented.
    assign res_valid    = fifo_valid;
    assign res_data     = fifo_valid ? rd_entry.data    : '0;
    assign res_new      = fifo_valid & rd_entry.pkt_new;
    assign res_errors   = fifo_valid ? rd_entry.errors  : '0;
    assign res_seq      = fifo_valid ? rd_entry.seq     : '0;
    assign res_uncorr   = fifo_valid & (rd_entry.errors > T_MAX_E);

    assign core_dta     = dta_q;
    assign core_synd    = synd_q;
    assign cnt_cw       = cnt_cw_q;
    assign cnt_corr_sym = cnt_corr_q;
    assign cnt_uncorr   = cnt_uncorr_q;
    assign err_timeout  = err_to_q;
    assign err_spurious = err_sp_q;

endmodule

// File: tb/tb_rs_decode_scheduler.sv
// tb/tb_rs_decode_scheduler.sv - directed self-checking bench for rs_decode_scheduler
module tb_rs_decode_scheduler;

    logic         aclk = 1'b0;
    logic         areset, enable, clear_fault;
    logic         cw_valid, cw_ready;
    logic [104:0] cw_data;
    logic [24:0]  cw_synd;
    logic         core_vld;
    logic [104:0] core_dta;
    logic [24:0]  core_synd;
    logic         core_pkt_vld, core_pkt_new;
    logic [104:0] core_pkt_dta;
    logic [2:0]   core_pkt_errors;
    logic         res_valid, res_ready, res_new, res_uncorr;
    logic [104:0] res_data;
    logic [2:0]   res_errors;
    logic [7:0]   res_seq;
    logic [15:0]  cnt_cw, cnt_corr_sym, cnt_uncorr;
    logic         err_timeout, err_spurious, busy;

    rs_decode_scheduler dut (
        .aclk(aclk), .areset(areset), .enable(enable), .clear_fault(clear_fault),
        .cw_valid(cw_valid), .cw_ready(cw_ready), .cw_data(cw_data), .cw_synd(cw_synd),
        .core_vld(core_vld), .core_dta(core_dta), .core_synd(core_synd),
        .core_pkt_vld(core_pkt_vld), .core_pkt_dta(core_pkt_dta),
        .core_pkt_new(core_pkt_new), .core_pkt_errors(core_pkt_errors),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_new(res_new), .res_errors(res_errors), .res_uncorr(res_uncorr),
        .res_seq(res_seq), .cnt_cw(cnt_cw), .cnt_corr_sym(cnt_corr_sym),
        .cnt_uncorr(cnt_uncorr), .err_timeout(err_timeout),
        .err_spurious(err_spurious), .busy(busy)
    );

    always #5 aclk = ~aclk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit ovf = 0;

    bit           core_auto;
    int           core_lat;
    int           pend_t[$];
    logic [104:0] pend_d[$];
    logic [2:0]   err_q[$];
    int           acc_q[$];
    int           rs_seq_q[$];
    int           rs_cyc_q[$];
    logic [2:0]   rs_err_q[$];
    logic         rs_unc_q[$];
    logic [104:0] rs_dat_q[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [104:0] pat(input int i);
        return {9'h1A5, 32'(i), 32'hDEADBEEF, 32'(i * 7 + 3)};
    endfunction

    // One clock: record handshakes of the current cycle, cross the edge,
    // then let the core model respond at edge+1.
    task automatic tick();
        #1;
        if (cw_valid && cw_ready) acc_q.push_back(cyc);
        if (res_valid && res_ready) begin
            rs_seq_q.push_back(int'(res_seq));
            rs_cyc_q.push_back(cyc);
            rs_err_q.push_back(res_errors);
            rs_unc_q.push_back(res_uncorr);
            rs_dat_q.push_back(res_data);
        end
        if (core_auto && core_vld) begin
            pend_t.push_back(cyc + core_lat);
            pend_d.push_back(core_dta);
        end
        if (dut.u_fifo.wr_en && dut.u_fifo.full && !dut.u_fifo.rd_en) ovf = 1;
        @(posedge aclk);
        #1;
        cyc++;
        if (core_auto) begin
            core_pkt_vld = 1'b0;
            if (pend_t.size() > 0 && pend_t[0] == cyc) begin
                void'(pend_t.pop_front());
                core_pkt_vld    = 1'b1;
                core_pkt_dta    = pend_d.pop_front();
                core_pkt_new    = 1'b1;
                core_pkt_errors = (err_q.size() > 0) ? err_q.pop_front() : 3'd0;
            end
        end
        #1;
    endtask

    task automatic clear_queues();
        pend_t.delete(); pend_d.delete(); err_q.delete(); acc_q.delete();
        rs_seq_q.delete(); rs_cyc_q.delete(); rs_err_q.delete();
        rs_unc_q.delete(); rs_dat_q.delete();
    endtask

    task automatic do_reset();
        areset = 1'b1; clear_fault = 1'b0; cw_valid = 1'b0; res_ready = 1'b0;
        core_auto = 1'b0; core_pkt_vld = 1'b0; core_pkt_new = 1'b0;
        core_pkt_dta = '0; core_pkt_errors = '0;
        clear_queues();
        tick();
        tick();
        areset = 1'b0;
        clear_queues();
    endtask

    task automatic send_n(input int n, input int limit);
        cw_valid = 1'b1;
        for (int i = 0; i < limit && acc_q.size() < n; i++) begin
            cw_data = pat(acc_q.size());
            tick();
        end
        cw_valid = 1'b0;
        chk("send_count", acc_q.size(), n);
    endtask

    task automatic wait_res(input int n, input int limit);
        for (int i = 0; i < limit && rs_seq_q.size() < n; i++) tick();
        chk("result_count", rs_seq_q.size(), n);
    endtask

    int exp_off[8] = '{0, 4, 8, 12, 23, 27, 31, 35};
    int t_iss;
    bit saw_vld;

    initial begin
        enable = 1'b0; cw_data = '0; cw_synd = '0; core_lat = 10;
        do_reset();

        // Reset state
        chk("rst_core_vld", core_vld, 0);
        chk("rst_cw_ready", cw_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_core_dta", core_dta, 0);
        chk("rst_cnt_cw", cnt_cw, 0);
        chk("rst_errs", {err_timeout, err_spurious}, 0);
        enable = 1'b1;
        tick();
        chk("en_cw_ready", cw_ready, 1);

        // Single codeword, core latency 10
        core_auto = 1'b1; core_lat = 10;
        cw_valid = 1'b1; cw_data = pat(100); cw_synd = '0;
        tick();
        cw_valid = 1'b0;
        chk("t1_accepted", acc_q.size(), 1);
        chk("t1_core_vld", core_vld, 1);
        chk("t1_core_dta", core_dta, pat(100));
        tick();
        chk("t1_core_vld_pulse", core_vld, 0);
        for (int i = 0; i < 50 && !res_valid; i++) tick();
        chk("t1_res_latency", cyc, acc_q[0] + 12);
        chk("t1_res_data", res_data, pat(100));
        chk("t1_res_flags", {res_new, res_errors, res_uncorr}, 5'b1_000_0);
        chk("t1_res_seq", res_seq, 0);
        chk("t1_cnt_cw", cnt_cw, 1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("t1_drained", {res_valid, busy}, 0);

        // Back-to-back, latency 20, four result slots
        do_reset();
        core_auto = 1'b1; core_lat = 20; res_ready = 1'b1; cw_valid = 1'b1;
        for (int i = 0; i < 300 && acc_q.size() < 8; i++) begin
            cw_data = pat(acc_q.size());
            cw_synd = 25'(acc_q.size());
            if (acc_q.size() == 4 && cyc == acc_q[0] + 18) chk("t2_credit_block", cw_ready, 0);
            tick();
        end
        cw_valid = 1'b0;
        chk("t2_accepts", acc_q.size(), 8);
        for (int i = 0; i < 8 && i < acc_q.size(); i++)
            chk($sformatf("t2_accept_time%0d", i), acc_q[i] - acc_q[0], exp_off[i]);
        wait_res(8, 200);
        for (int i = 0; i < rs_seq_q.size(); i++) begin
            chk($sformatf("t2_seq%0d", i), rs_seq_q[i], i);
            chk($sformatf("t2_data%0d", i), rs_dat_q[i], pat(i));
        end

        // Backpressure: four buffered results hold off further issues
        do_reset();
        core_auto = 1'b1; core_lat = 5; cw_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cw_data = pat(acc_q.size());
            tick();
        end
        chk("t3_accepts_held", acc_q.size(), 4);
        chk("t3_cw_ready_low", cw_ready, 0);
        chk("t3_res_head", {res_valid, res_seq}, {1'b1, 8'd0});
        tick();
        chk("t3_hold_data", res_data, pat(0));
        chk("t3_hold_seq", res_seq, 0);
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cw_data = pat(acc_q.size());
            tick();
        end
        cw_valid = 1'b0;
        chk("t3_drained4", rs_seq_q.size(), 4);
        for (int i = 1; i < 4 && i < rs_seq_q.size(); i++) begin
            chk($sformatf("t3_read_cyc%0d", i), rs_cyc_q[i], rs_cyc_q[0] + i);
            chk($sformatf("t3_read_seq%0d", i), rs_seq_q[i], i);
        end
        chk("t3_resume_accepts", acc_q.size(), 5);
        if (acc_q.size() == 5 && rs_cyc_q.size() > 0)
            chk("t3_resume_time", acc_q[4], rs_cyc_q[0] + 1);

        // Error statistics
        do_reset();
        core_auto = 1'b1; core_lat = 3; res_ready = 1'b1;
        err_q.push_back(3'd1); err_q.push_back(3'd2); err_q.push_back(3'd3);
        send_n(3, 60);
        wait_res(3, 100);
        for (int i = 0; i < 3 && i < rs_err_q.size(); i++) begin
            chk($sformatf("t4_err%0d", i), rs_err_q[i], i + 1);
            chk($sformatf("t4_uncorr%0d", i), rs_unc_q[i], (i == 2) ? 1 : 0);
        end
        chk("t4_cnt_corr_sym", cnt_corr_sym, 3);
        chk("t4_cnt_uncorr", cnt_uncorr, 1);
        chk("t4_cnt_cw", cnt_cw, 3);

        // Watchdog timeout, spurious completion, clear_fault
        do_reset();
        send_n(1, 10);
        t_iss = cyc;
        chk("t5_issue", core_vld, 1);
        while (cyc < t_iss + 255) begin
            clear_fault = (cyc == t_iss + 20);
            tick();
        end
        clear_fault = 1'b0;
        chk("t5_before_expiry", {err_timeout, busy}, 2'b01);
        tick();
        chk("t5_err_timeout", err_timeout, 1);
        chk("t5_fault_ready", cw_ready, 0);
        core_pkt_vld = 1'b1; core_pkt_dta = pat(9);
        tick();
        core_pkt_vld = 1'b0;
        chk("t5_err_spurious", err_spurious, 1);
        chk("t5_spurious_dropped", {res_valid, cnt_cw}, 0);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        chk("t5_cleared_flags", {err_timeout, err_spurious}, 0);
        chk("t5_cleared_ready", {cw_ready, busy}, 2'b10);

        // Reset during GAP with two in flight
        do_reset();
        cw_synd = 25'h1ABCDEF;
        send_n(2, 20);
        tick();
        chk("t6_busy_gap", {busy, core_vld}, 2'b10);
        areset = 1'b1;
        tick();
        areset = 1'b0;
        chk("t6_rst_outputs", {core_vld, res_valid, busy, err_timeout, err_spurious}, 0);
        chk("t6_rst_core_dta", core_dta, 0);
        chk("t6_rst_core_synd", core_synd, 0);
        chk("t6_rst_cnt", cnt_cw, 0);
        saw_vld = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            saw_vld |= core_vld;
        end
        chk("t6_no_core_vld", saw_vld, 0);

        chk("fifo_no_overflow", ovf, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
